pipelined_adder: RTL

Parametrised, pipelined ripple-carry adder/subtractor for the multiplier datapath, superseding the single-bit combinational full adder cell where wide operands must close timing. Operands are split into `STAGES` equal chunks. Each pipeline stage adds one chunk and registers its carry into the next stage. Skew registers align operand and result chunks. The block accepts one operation per cycle under a valid/ready handshake and adds subtract mode, carry-out and signed-overflow flags.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder: one valid/ready channel in, one out.
// Handshake: a beat moves on a rising edge where valid and ready are both 1; ready never depends on valid.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: stage k adds operand chunk k and registers
// its carry into stage k+1; skew registers line up each beat's operand and result chunks.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    pipelined_adder_if.slave io_bus
);
    localparam int CW = WIDTH / STAGES;

    logic              w_adv;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic [STAGES:0]   w_carry;
    logic [WIDTH-1:0]  w_sum;
    logic              w_ovf;
    logic [STAGES-1:0] r_v;

    // The whole pipeline moves as one; it only stalls while a finished result is refused.
    assign w_adv      = ~r_v[STAGES-1] | io_bus.out_ready;
    assign w_b_eff    = io_bus.in_sub ? ~io_bus.in_b : io_bus.in_b;
    assign w_c0       = io_bus.in_sub | io_bus.in_cin;
    assign w_carry[0] = w_c0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v <= '0;
        end else if (w_adv) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                r_v[k] <= r_v[k-1];
            end
            r_v[0] <= io_bus.in_valid;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int D = STAGES - 1 - k;

        logic [CW-1:0] w_a_op;
        logic [CW-1:0] w_b_op;
        logic          w_cin;
        logic [CW:0]   w_full;
        logic [CW-1:0] r_sum;
        logic          r_cout;

        if (k == 0) begin : g_first
            assign w_a_op = io_bus.in_a[CW-1:0];
            assign w_b_op = w_b_eff[CW-1:0];
        end else begin : g_skew
            // Chunk k of a beat is needed k cycles after acceptance, when its carry arrives.
            logic [CW-1:0] r_a_dly [k];
            logic [CW-1:0] r_b_dly [k];

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int j = 0; j < k; j++) begin
                        r_a_dly[j] <= '0;
                        r_b_dly[j] <= '0;
                    end
                end else if (w_adv) begin
                    r_a_dly[0] <= io_bus.in_a[k*CW +: CW];
                    r_b_dly[0] <= w_b_eff[k*CW +: CW];
                    for (int j = 1; j < k; j++) begin
                        r_a_dly[j] <= r_a_dly[j-1];
                        r_b_dly[j] <= r_b_dly[j-1];
                    end
                end
            end

            assign w_a_op = r_a_dly[k-1];
            assign w_b_op = r_b_dly[k-1];
        end

        assign w_cin  = w_carry[k];
        assign w_full = {1'b0, w_a_op} + {1'b0, w_b_op} + {{CW{1'b0}}, w_cin};

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_sum  <= '0;
                r_cout <= 1'b0;
            end else if (w_adv) begin
                r_sum  <= w_full[CW-1:0];
                r_cout <= w_full[CW];
            end
        end

        assign w_carry[k+1] = r_cout;

        if (D == 0) begin : g_sum_direct
            assign w_sum[k*CW +: CW] = r_sum;
        end else begin : g_sum_skew
            // Early chunks wait for the final stage so the whole result leaves together.
            logic [CW-1:0] r_s_dly [D];

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int j = 0; j < D; j++) begin
                        r_s_dly[j] <= '0;
                    end
                end else if (w_adv) begin
                    r_s_dly[0] <= r_sum;
                    for (int j = 1; j < D; j++) begin
                        r_s_dly[j] <= r_s_dly[j-1];
                    end
                end
            end

            assign w_sum[k*CW +: CW] = r_s_dly[D-1];
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            // Carry into the MSB is recovered from the MSB slice as a ^ b ^ sum.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_a_op[CW-1] ^ w_b_op[CW-1] ^ w_full[CW-1] ^ w_full[CW];
                end
            end

            assign w_ovf = r_ovf;
        end
    end

    assign io_bus.in_ready  = w_adv;
    assign io_bus.out_valid = r_v[STAGES-1];
    assign io_bus.out_sum   = w_sum;
    assign io_bus.out_cout  = w_carry[STAGES];
    assign io_bus.out_ovf   = w_ovf;
endmodule
